// File: rtl/cfg_timeout_monitor.sv
// Single-outstanding Avalon-MM config pass-through with a per-command watchdog.
// A device that never completes is cut off with an all-ones SLVERR completion and a timeout_o pulse.
module cfg_timeout_monitor #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [REG_WIDTH-1:0]    timeout_reg_i,
    input  logic [ADDR_WIDTH-1:0]   h_address_i,
    input  logic [DATA_WIDTH-1:0]   h_writedata_i,
    input  logic [DATA_WIDTH/8-1:0] h_byteenable_i,
    input  logic                    h_read_i,
    input  logic                    h_write_i,
    output logic                    h_waitrequest_o,
    output logic [DATA_WIDTH-1:0]   h_readdata_o,
    output logic                    h_readdatavalid_o,
    output logic [1:0]              h_response_o,
    output logic [ADDR_WIDTH-1:0]   d_address_o,
    output logic [DATA_WIDTH-1:0]   d_writedata_o,
    output logic [DATA_WIDTH/8-1:0] d_byteenable_o,
    output logic                    d_read_o,
    output logic                    d_write_o,
    input  logic                    d_waitrequest_i,
    input  logic                    d_readdatavalid_i,
    input  logic [DATA_WIDTH-1:0]   d_readdata_i,
    input  logic [1:0]              d_response_i,
    output logic                    timeout_o,
    output logic [CNT_WIDTH-1:0]    timeout_cnt_o,
    output logic                    busy_o,
    output logic [2:0]              dbg_state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_RDWAIT = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] be_q, be_d;
    logic                    is_write_q, is_write_d;
    logic [REG_WIDTH-1:0]    n_q, n_d;
    logic [REG_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    drain_q, drain_d;
    logic                    timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]    tcnt_q, tcnt_d;
    logic [DATA_WIDTH-1:0]   h_rdata_q, h_rdata_d;
    logic [1:0]              h_resp_q, h_resp_d;
    logic                    h_rdv_q, h_rdv_d;

    logic                    expire;
    logic                    do_abort;
    logic [REG_WIDTH-1:0]    cnt_dec;

    // A count of 0 means the watchdog is disabled; it never decrements and never reaches 1.
    assign expire  = (cnt_q == REG_WIDTH'(1));
    assign cnt_dec = (cnt_q != '0) ? (cnt_q - REG_WIDTH'(1)) : cnt_q;

    // Handshakes: the host command is taken whenever a strobe is high in IDLE and is completed
    // by h_waitrequest_o low for the single RESP cycle; the device strobe is held through CMD
    // until d_waitrequest_i is low, and read data is qualified by d_readdatavalid_i alone.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        is_write_d = is_write_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        drain_d    = drain_q;
        timeout_d  = 1'b0;
        tcnt_d     = tcnt_q;
        h_rdata_d  = h_rdata_q;
        h_resp_d   = h_resp_q;
        h_rdv_d    = 1'b0;
        do_abort   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (h_write_i || h_read_i) begin
                    addr_d     = h_address_i;
                    wdata_d    = h_writedata_i;
                    be_d       = h_byteenable_i;
                    is_write_d = h_write_i;
                    n_d        = timeout_reg_i;
                    cnt_d      = timeout_reg_i;
                    drain_d    = 1'b0;
                    state_d    = S_CMD;
                end
            end
            S_CMD: begin
                cnt_d = cnt_dec;
                if (!d_waitrequest_i && is_write_q) begin
                    resp_d  = RESP_OKAY;
                    state_d = S_RESP;
                end else if (expire) begin
                    // A read accepted in the expiry cycle still owes us a data beat.
                    do_abort = 1'b1;
                    drain_d  = !d_waitrequest_i;
                end else if (!d_waitrequest_i) begin
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                cnt_d = cnt_dec;
                if (d_readdatavalid_i) begin
                    rdata_d = d_readdata_i;
                    resp_d  = d_response_i;
                    state_d = S_RESP;
                end else if (expire) begin
                    do_abort = 1'b1;
                    drain_d  = 1'b1;
                end
            end
            S_RESP: begin
                h_rdv_d  = !is_write_q;
                h_resp_d = resp_q;
                if (!is_write_q) begin
                    h_rdata_d = rdata_q;
                end
                cnt_d   = n_q;
                state_d = drain_q ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                // The late beat is swallowed; a second expiry here is silent.
                if (d_readdatavalid_i || expire) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_abort) begin
            rdata_d   = '1;
            resp_d    = RESP_SLVERR;
            timeout_d = 1'b1;
            tcnt_d    = (tcnt_q == '1) ? tcnt_q : (tcnt_q + CNT_WIDTH'(1));
            state_d   = S_RESP;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            is_write_q <= 1'b0;
            n_q        <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            resp_q     <= '0;
            drain_q    <= 1'b0;
            timeout_q  <= 1'b0;
            tcnt_q     <= '0;
            h_rdata_q  <= '0;
            h_resp_q   <= '0;
            h_rdv_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            is_write_q <= is_write_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            drain_q    <= drain_d;
            timeout_q  <= timeout_d;
            tcnt_q     <= tcnt_d;
            h_rdata_q  <= h_rdata_d;
            h_resp_q   <= h_resp_d;
            h_rdv_q    <= h_rdv_d;
        end
    end

    assign h_waitrequest_o   = (state_q != S_RESP);
    assign h_readdata_o      = h_rdata_q;
    assign h_readdatavalid_o = h_rdv_q;
    assign h_response_o      = h_resp_q;
    assign d_address_o       = addr_q;
    assign d_writedata_o     = wdata_q;
    assign d_byteenable_o    = be_q;
    assign d_read_o          = (state_q == S_CMD) && !is_write_q;
    assign d_write_o         = (state_q == S_CMD) && is_write_q;
    assign timeout_o         = timeout_q;
    assign timeout_cnt_o     = tcnt_q;
    assign busy_o            = (state_q != S_IDLE);
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_cfg_timeout_monitor.sv
// Bench for cfg_timeout_monitor: table of host transactions with a scripted device model,
// read completions scored against an expected queue, plus drain, reset and saturation sequences.
module tb_cfg_timeout_monitor;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 32;
    // A narrow event counter keeps the saturation sequence short.
    localparam int CW = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RDWAIT = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic [RW-1:0] timeout_reg_i;
    logic [AW-1:0] h_address_i;
    logic [DW-1:0] h_writedata_i;
    logic [3:0]    h_byteenable_i;
    logic          h_read_i, h_write_i;
    logic          h_waitrequest_o;
    logic [DW-1:0] h_readdata_o;
    logic          h_readdatavalid_o;
    logic [1:0]    h_response_o;
    logic [AW-1:0] d_address_o;
    logic [DW-1:0] d_writedata_o;
    logic [3:0]    d_byteenable_o;
    logic          d_read_o, d_write_o;
    logic          d_waitrequest_i, d_readdatavalid_i;
    logic [DW-1:0] d_readdata_i;
    logic [1:0]    d_response_i;
    logic          timeout_o;
    logic [CW-1:0] timeout_cnt_o;
    logic          busy_o;
    logic [2:0]    dbg_state_o;

    cfg_timeout_monitor #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_WIDTH(RW), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .timeout_reg_i(timeout_reg_i),
        .h_address_i(h_address_i), .h_writedata_i(h_writedata_i), .h_byteenable_i(h_byteenable_i),
        .h_read_i(h_read_i), .h_write_i(h_write_i), .h_waitrequest_o(h_waitrequest_o),
        .h_readdata_o(h_readdata_o), .h_readdatavalid_o(h_readdatavalid_o), .h_response_o(h_response_o),
        .d_address_o(d_address_o), .d_writedata_o(d_writedata_o), .d_byteenable_o(d_byteenable_o),
        .d_read_o(d_read_o), .d_write_o(d_write_o), .d_waitrequest_i(d_waitrequest_i),
        .d_readdatavalid_i(d_readdatavalid_i), .d_readdata_i(d_readdata_i), .d_response_i(d_response_i),
        .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    // ---------------- vector table ----------------
    // acc_k / rdv_m: cycle (relative to T0) at which the device drops waitrequest / returns data; -1 = never.
    typedef struct {
        logic        wr;
        logic        both;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] n;
        int          acc_k;
        int          rdv_m;
        logic [31:0] dev_data;
        logic [1:0]  dev_resp;
        int          exp_wait_t;
        logic        exp_to;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          busy_until;
        int          len;
    } vec_t;

    vec_t vecs[10];
    vec_t sat_v;

    // ---------------- scoreboard ----------------
    logic [33:0]   exp_q[$];
    int            exp_cyc_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [CW-1:0] tcnt_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_tcnt();
        tcnt_m = (tcnt_m == '1) ? tcnt_m : tcnt_m + 1'b1;
    endtask

    task automatic mon_rdv(input int t);
        logic [33:0] e;
        int          c;
        if (h_readdatavalid_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rdv: got readdatavalid data %0h at cycle %0d, required none",
                         h_readdata_o, t);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                chk("rdv_cycle", t, c);
                chk("rdv_data", h_readdata_o, e[31:0]);
                chk("rdv_resp", h_response_o, e[33:32]);
            end
        end
    endtask

    task automatic idle_inputs();
        h_read_i          = 1'b0;
        h_write_i         = 1'b0;
        d_waitrequest_i   = 1'b1;
        d_readdatavalid_i = 1'b0;
    endtask

    // ---------------- driver: one table transaction ----------------
    task automatic run_vec(input vec_t v);
        int wait_first, wait_cnt, to_first, to_cnt, last_busy;
        wait_first = -1; wait_cnt = 0; to_first = -1; to_cnt = 0; last_busy = -1;
        for (int t = 0; t < v.len; t++) begin
            h_write_i       = (t == 0) && v.wr;
            h_read_i        = (t == 0) && (!v.wr || v.both);
            h_address_i     = v.addr;
            h_writedata_i   = v.wdata;
            h_byteenable_i  = v.be;
            if (t == 0) begin
                timeout_reg_i = v.n;
                if (!v.wr) begin
                    exp_q.push_back({v.exp_resp, v.exp_rdata});
                    exp_cyc_q.push_back(v.exp_wait_t + 1);
                end
            end else begin
                timeout_reg_i = $urandom_range(1, 3);
            end
            d_waitrequest_i   = !(t == v.acc_k);
            d_readdatavalid_i = (t == v.rdv_m);
            d_readdata_i      = (t == v.rdv_m) ? v.dev_data : $urandom();
            d_response_i      = v.dev_resp;
            @(negedge clk);
            if (t == 1) begin
                chk("d_address", d_address_o, v.addr);
                chk("d_byteenable", d_byteenable_o, v.be);
                chk("d_write", d_write_o, v.wr);
                chk("d_read", d_read_o, !v.wr);
                if (v.wr) chk("d_writedata", d_writedata_o, v.wdata);
            end
            if (!h_waitrequest_o) begin
                wait_cnt++;
                if (wait_first < 0) wait_first = t;
            end
            if (timeout_o) begin
                to_cnt++;
                if (to_first < 0) to_first = t;
            end
            if (busy_o) last_busy = t;
            if (v.wr && t == v.exp_wait_t + 1) chk("write_resp", h_response_o, v.exp_resp);
            mon_rdv(t);
            tick();
        end
        idle_inputs();
        if (v.exp_to) bump_tcnt();
        chk("wait_low_cycle", wait_first, v.exp_wait_t);
        chk("wait_low_count", wait_cnt, 1);
        chk("timeout_pulses", to_cnt, v.exp_to);
        if (v.exp_to) chk("timeout_cycle", to_first, v.exp_wait_t);
        chk("busy_last_cycle", last_busy, v.busy_until);
        chk("timeout_cnt", timeout_cnt_o, tcnt_m);
        chk("end_state", dbg_state_o, S_IDLE);
        chk("rdv_missing", exp_q.size(), 0);
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        int to_cnt, to_first, first_rd, stray;

        //            wr both addr       wdata           be    n    acc rdv   dev_data        dresp  wait to exp_rdata       eresp busy len
        vecs[0] = '{1, 0, 32'h10, 32'hA5A5_0001, 4'hF, 100,  4,  -1, 32'h0,          2'b00, 5,    0, 32'h0,          2'b00, 5,    8};
        vecs[1] = '{0, 0, 32'h20, 32'h0,         4'hF, 100,  2,   8, 32'h1234_5678,  2'b00, 9,    0, 32'h1234_5678,  2'b00, 9,    12};
        vecs[2] = '{0, 0, 32'h24, 32'h0,         4'hF, 20,  -1,  -1, 32'h0,          2'b00, 21,   1, 32'hFFFF_FFFF,  2'b10, 21,   24};
        vecs[3] = '{0, 0, 32'h28, 32'h0,         4'hF, 20,   1,  30, 32'h5555_AAAA,  2'b00, 21,   1, 32'hFFFF_FFFF,  2'b10, 30,   33};
        vecs[4] = '{0, 0, 32'h2C, 32'h0,         4'h3, 10,   1,  10, 32'h0BAD_F00D,  2'b00, 11,   0, 32'h0BAD_F00D,  2'b00, 11,   14};
        vecs[5] = '{1, 0, 32'h30, 32'h0000_0066, 4'h1, 6,    6,  -1, 32'h0,          2'b00, 7,    0, 32'h0,          2'b00, 7,    10};
        vecs[6] = '{1, 0, 32'h34, 32'h0000_0067, 4'h2, 6,    7,  -1, 32'h0,          2'b00, 7,    1, 32'h0,          2'b10, 7,    10};
        vecs[7] = '{0, 0, 32'h38, 32'h0,         4'hF, 0,    3, 5000, 32'h0000_5000, 2'b00, 5001, 0, 32'h0000_5000,  2'b00, 5001, 5004};
        vecs[8] = '{0, 0, 32'h3C, 32'h0,         4'hC, 50,   1,   3, 32'h0000_0001,  2'b10, 4,    0, 32'h0000_0001,  2'b10, 4,    7};
        vecs[9] = '{1, 1, 32'h44, 32'hFACE_0009, 4'hF, 10,   2,  -1, 32'h0,          2'b00, 3,    0, 32'h0,          2'b00, 3,    6};
        sat_v   = '{1, 0, 32'h50, 32'h0,         4'hF, 1,   -1,  -1, 32'h0,          2'b00, 2,    1, 32'h0,          2'b10, 2,    4};

        rstn_i = 1'b0;
        idle_inputs();
        timeout_reg_i  = '0;
        h_address_i    = '0;
        h_writedata_i  = '0;
        h_byteenable_i = '0;
        d_readdata_i   = '0;
        d_response_i   = '0;
        tcnt_m         = '0;
        repeat (2) @(negedge clk);
        chk("rst_waitrequest", h_waitrequest_o, 1'b1);
        chk("rst_rdv", h_readdatavalid_o, 1'b0);
        chk("rst_timeout", timeout_o, 1'b0);
        chk("rst_timeout_cnt", timeout_cnt_o, 0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_d_strobes", {d_read_o, d_write_o}, 2'b00);
        tick();
        rstn_i = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Aborted read drains for a fresh N cycles while a new host read waits.
        to_cnt = 0; to_first = -1; first_rd = -1;
        for (int t = 0; t < 25; t++) begin
            h_read_i          = (t == 0) || (t >= 10 && t <= 18);
            h_address_i       = 32'h40;
            h_byteenable_i    = 4'hF;
            timeout_reg_i     = (t == 0) ? 32'd8 : 32'd4;
            d_waitrequest_i   = !(t == 1 || t == 19);
            d_readdatavalid_i = (t == 20);
            d_readdata_i      = 32'hCAFE_0042;
            d_response_i      = 2'b00;
            if (t == 0) begin
                exp_q.push_back({2'b10, 32'hFFFF_FFFF});
                exp_cyc_q.push_back(10);
            end
            if (t == 10) begin
                exp_q.push_back({2'b00, 32'hCAFE_0042});
                exp_cyc_q.push_back(22);
            end
            @(negedge clk);
            if (timeout_o) begin
                to_cnt++;
                if (to_first < 0) to_first = t;
            end
            if (t >= 10 && d_read_o && first_rd < 0) first_rd = t;
            if (t == 17) chk("drain_state", dbg_state_o, S_DRAIN);
            if (t == 18) chk("drain_exit_idle", dbg_state_o, S_IDLE);
            mon_rdv(t);
            tick();
        end
        idle_inputs();
        bump_tcnt();
        chk("drain_timeout_pulses", to_cnt, 1);
        chk("drain_timeout_cycle", to_first, 9);
        chk("drain_blocks_cmd", first_rd, 19);
        chk("drain_timeout_cnt", timeout_cnt_o, tcnt_m);
        chk("drain_rdv_missing", exp_q.size(), 0);
        exp_q.delete();
        exp_cyc_q.delete();

        // Reset in RDWAIT, then a late beat and a stray beat must go nowhere.
        h_read_i = 1'b1; h_address_i = 32'h60; timeout_reg_i = 32'd100;
        tick();
        h_read_i = 1'b0; d_waitrequest_i = 1'b0;
        tick();
        d_waitrequest_i = 1'b1;
        tick();
        tick();
        chk("pre_reset_state", dbg_state_o, S_RDWAIT);
        rstn_i = 1'b0;
        #2;
        chk("mid_rst_waitrequest", h_waitrequest_o, 1'b1);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_d_read", d_read_o, 1'b0);
        chk("mid_rst_d_address", d_address_o, 0);
        chk("mid_rst_timeout_cnt", timeout_cnt_o, 0);
        chk("mid_rst_rdata", {h_response_o, h_readdata_o}, 0);
        tcnt_m = '0;
        @(negedge clk);
        rstn_i = 1'b1;
        tick();
        stray = 0;
        for (int t = 0; t < 8; t++) begin
            d_readdatavalid_i = (t == 2 || t == 5);
            d_readdata_i      = 32'hDEAD_BEEF;
            @(negedge clk);
            if (h_readdatavalid_o || busy_o || !h_waitrequest_o) stray++;
            tick();
        end
        idle_inputs();
        chk("post_reset_stray", stray, 0);

        // Event counter saturates at all-ones.
        for (int i = 0; i < (1 << CW); i++) run_vec(sat_v);
        chk("sat_hold", timeout_cnt_o, {CW{1'b1}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cfg_timeout_monitor.md
# cfg_timeout_monitor

Single-outstanding Avalon-MM pass-through between the HPS lightweight bridge (host side) and the P-tile configuration-access slave (device side). It forwards config reads and writes, and counts cycles against the programmable `timeout_reg` value from the CSR block. On expiry it completes the host transfer with an all-ones error response and pulses `timeout_o`, which drives the CSR block's `timeout` input to set ERROR_STAT[1]. This prevents a hung endpoint from stalling the HPS.

## Interface
Parameters:
- ADDR_WIDTH, 32, host/device address width
- DATA_WIDTH, 32, data width
- REG_WIDTH, 32, width of timeout value
- CNT_WIDTH, 16, width of timeout event counter

Ports:
- clk_i  in  1  single clock for all logic
- rstn_i  in  1  reset; asynchronous, active-low
- timeout_reg_i  in  REG_WIDTH  timeout in clk_i cycles; 0 = disabled
- h_address_i / h_writedata_i / h_byteenable_i  in  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  host command
- h_read_i, h_write_i  in  1  host command strobes
- h_waitrequest_o  out  1  low for exactly one cycle to accept the command
- h_readdata_o  out  DATA_WIDTH  read data
- h_readdatavalid_o  out  1  read data qualifier
- h_response_o  out  2  00 OKAY, 10 SLVERR
- d_address_o / d_writedata_o / d_byteenable_o  out  as host  latched command
- d_read_o, d_write_o  out  1  device command strobes
- d_waitrequest_i, d_readdatavalid_i  in  1  device handshake
- d_readdata_i  in  DATA_WIDTH; d_response_i  in  2
- timeout_o  out  1  one-cycle pulse per timeout event
- timeout_cnt_o  out  CNT_WIDTH  saturating count of timeout events
- busy_o  out  1  high in any state except IDLE

## Operation
- States: IDLE, CMD, RDWAIT, RESP, DRAIN.
- IDLE:
  - When h_write_i or h_read_i is high, latch address, data, byte enables and direction.
  - Snapshot N = timeout_reg_i into the down-counter.
  - Go to CMD.
  - If write and read are both high, the write wins.
- CMD:
  - d_write_o or d_read_o is high with the latched fields.
  - Write accepted (d_waitrequest_i=0): go to RESP with response OKAY.
  - Read accepted: drop d_read_o and go to RDWAIT.
- RDWAIT: on d_readdatavalid_i, capture d_readdata_i and d_response_i, then go to RESP.
- Counter:
  - Decrements every cycle in CMD or RDWAIT.
  - Expiry = no completion within N cycles of the first cycle in CMD.
  - On expiry:
    - Drop the d_* strobes.
    - Pulse timeout_o.
    - Increment timeout_cnt_o; it saturates at all-ones.
    - Data = all-ones (DATA_WIDTH'hFFFF_FFFF), response = 10.
    - Go to RESP with the abort flag set.
- N=0: the counter is disabled and the block waits indefinitely.
- A completion in the same cycle as expiry wins: no timeout_o, and the normal data is returned.
- A timeout_reg_i change mid-transfer has no effect; it applies to the next command.
- RESP:
  - h_waitrequest_o=0 for one cycle.
  - Next state is DRAIN if a read was aborted after acceptance by the device (it was in RDWAIT); otherwise IDLE.
- DRAIN:
  - Blocks new host commands.
  - Exits to IDLE when the late d_readdatavalid_i arrives (that data is discarded) or after a fresh N-cycle count expires.
  - Drain expiry raises no timeout_o.
- Reset values:
  - h_waitrequest_o=1.
  - All other outputs 0, including timeout_cnt_o.
  - State IDLE.
- Reset mid-transfer returns immediately to IDLE. A stray d_readdatavalid_i in IDLE is ignored.

## Timing
- Host asserts a command at T0 in IDLE:
  - T1: CMD, d_* valid.
  - Device accepts at Tk: RESP at Tk+1.
- Write completion:
  - h_waitrequest_o=0 at Tk+1.
  - IDLE at Tk+2.
- Read completion:
  - d_readdatavalid_i at Tm: RESP at Tm+1.
  - h_readdatavalid_o=1 with h_readdata_o/h_response_o at Tm+2, registered, for one cycle.
  - IDLE at Tm+2, so a new command is sampled at Tm+2 at the earliest.
- Timeout with no device response in cycles T1..TN:
  - T(N+1): RESP with timeout_o=1 and h_waitrequest_o=0.
  - Read data valid at T(N+2).
- h_waitrequest_o is high in every cycle except RESP.
- h_readdatavalid_o is never asserted for writes.

## Test plan
- Write to addr 0x10, device waitrequest low after 3 cycles, N=100 -> h_waitrequest_o low exactly once at T5; no timeout_o.
- Read, device returns 0x1234_5678 at Tm=8, N=100 -> h_readdatavalid_o at T10 with data 0x12345678 and response 00.
- Read with device never accepting, N=20 -> timeout_o pulse at T21, readdata 0xFFFFFFFF, response 10 at T22, timeout_cnt_o=1.
- Read accepted, data late: N=20 with data arriving at T30 -> abort at T21, DRAIN swallows the data at T30, and the next host read stalls until IDLE.
- Completion in the expiry cycle (d_readdatavalid_i at TN) -> normal data, no timeout_o. Also N=0 with a 5000-cycle response -> no timeout.
- Reset mid-RDWAIT, then late d_readdatavalid_i -> outputs at reset values, nothing forwarded; timeout_cnt_o preset to 0xFFFF then one more timeout -> stays 0xFFFF.
